// File: rtl/fios_pkg.sv
// Shared types for the FIOS operand server: word width, FSM states and load targets.
package fios_pkg;
    localparam int WORD_W = 17;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} opsrv_state_t;
    typedef enum logic [1:0] {SEL_A, SEL_B, SEL_P, SEL_NONE} load_sel_t;
endpackage

// File: rtl/fios_word_ram.sv
// Word buffer with one synchronous write port and one asynchronous read port that
// returns RD_WORDS consecutive words from a base address (words past DEPTH read 0).
module fios_word_ram
    import fios_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = 4,
    parameter int RD_WORDS = 1
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [AW-1:0]              waddr_i,
    input  logic [WORD_W-1:0]          wdata_i,
    input  logic [AW-1:0]              raddr_i,
    output logic [RD_WORDS*WORD_W-1:0] rdata_o
);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem[waddr_i[MW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int j = 0; j < RD_WORDS; j++) begin
            if (int'(raddr_i) + j < DEPTH) begin
                rdata_o[j*WORD_W +: WORD_W] = mem[MW'(int'(raddr_i) + j)];
            end
        end
    end
endmodule

// File: rtl/fios_operand_server.sv
// Host-facing operand/result buffer for the FIOS multiplier port set.
// Optional push-count checking on err_o is built with FIOS_OPSRV_PUSH_CHECK_EN.
module fios_operand_server
    import fios_pkg::*;
#(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    load_valid_i,
    input  logic [1:0]              load_sel_i,
    input  logic [WORD_W-1:0]       load_data_i,
    output logic                    load_ready_o,
    input  logic                    go_i,
    output logic                    busy_o,
    output logic                    start_o,
    output logic [PE_NB*WORD_W-1:0] a_o,
    input  logic                    a_shift_i,
    output logic [WORD_W-1:0]       b_o,
    input  logic                    b_fetch_i,
    output logic [WORD_W-1:0]       p_o,
    input  logic                    p_fetch_i,
    input  logic [WORD_W-1:0]       res_i,
    input  logic                    res_push_i,
    input  logic                    done_i,
    output logic                    res_valid_o,
    input  logic                    res_rd_i,
    output logic [WORD_W-1:0]       res_data_o,
    output logic                    err_o
);
    localparam int A_GROUPS = (s + PE_NB - 1) / PE_NB;
    localparam int IDX_W    = $clog2(s + 1);
    localparam logic [IDX_W-1:0] S_IDX    = IDX_W'(s);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(s - 1);
    localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(A_GROUPS - 1);

    opsrv_state_t state_q, state_d;
    logic [IDX_W-1:0] a_ld_q, a_ld_d, b_ld_q, b_ld_d, p_ld_q, p_ld_d;
    logic [IDX_W-1:0] grp_q, grp_d, b_idx_q, b_idx_d, p_idx_q, p_idx_d;
    logic [IDX_W-1:0] push_q, push_d, rd_idx_q, rd_idx_d;
    logic             start_q, start_d;
    logic [PE_NB*WORD_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] a_base;
    logic [WORD_W-1:0] b_rd, p_rd, r_rd;
    logic a_we, b_we, p_we, r_we;
    logic load_hit, go_accept;
    load_sel_t sel;

    assign sel       = load_sel_t'(load_sel_i);
    assign load_hit  = load_valid_i && (sel != SEL_NONE);
    assign go_accept = (state_q != RUN) && go_i &&
                       (a_ld_q == S_IDX) && (b_ld_q == S_IDX) && (p_ld_q == S_IDX);

    always_comb begin
        state_d  = state_q;
        a_ld_d   = a_ld_q;
        b_ld_d   = b_ld_q;
        p_ld_d   = p_ld_q;
        grp_d    = grp_q;
        b_idx_d  = b_idx_q;
        p_idx_d  = p_idx_q;
        push_d   = push_q;
        rd_idx_d = rd_idx_q;
        start_d  = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        p_we     = 1'b0;
        r_we     = 1'b0;
        case (state_q)
            RUN: begin
                if (a_shift_i) grp_d   = (grp_q == LAST_GRP)   ? '0 : grp_q + 1'b1;
                if (b_fetch_i) b_idx_d = (b_idx_q == LAST_IDX) ? '0 : b_idx_q + 1'b1;
                if (p_fetch_i) p_idx_d = (p_idx_q == LAST_IDX) ? '0 : p_idx_q + 1'b1;
                if (res_push_i && (push_q != S_IDX)) begin
                    r_we   = 1'b1;
                    push_d = push_q + 1'b1;
                end
                if (done_i) state_d = DONE;
            end
            default: begin
                if ((state_q == DONE) && res_rd_i) begin
                    rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
                end
                // Load indices saturate at s so surplus words never overwrite.
                if (load_hit) begin
                    state_d  = LOAD;
                    rd_idx_d = '0;
                    case (sel)
                        SEL_A: if (a_ld_q != S_IDX) begin a_we = 1'b1; a_ld_d = a_ld_q + 1'b1; end
                        SEL_B: if (b_ld_q != S_IDX) begin b_we = 1'b1; b_ld_d = b_ld_q + 1'b1; end
                        SEL_P: if (p_ld_q != S_IDX) begin p_we = 1'b1; p_ld_d = p_ld_q + 1'b1; end
                        default: ;
                    endcase
                end
                if (go_accept) begin
                    state_d  = RUN;
                    start_d  = 1'b1;
                    a_ld_d   = '0;
                    b_ld_d   = '0;
                    p_ld_d   = '0;
                    grp_d    = '0;
                    b_idx_d  = '0;
                    p_idx_d  = '0;
                    push_d   = '0;
                    rd_idx_d = '0;
                end
            end
        endcase
    end

    // a_o is fetched with the next group index so it is ready in the start_o cycle.
    assign a_base = IDX_W'(int'(grp_d) * PE_NB);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            a_ld_q   <= '0;
            b_ld_q   <= '0;
            p_ld_q   <= '0;
            grp_q    <= '0;
            b_idx_q  <= '0;
            p_idx_q  <= '0;
            push_q   <= '0;
            rd_idx_q <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_ld_q   <= a_ld_d;
            b_ld_q   <= b_ld_d;
            p_ld_q   <= p_ld_d;
            grp_q    <= grp_d;
            b_idx_q  <= b_idx_d;
            p_idx_q  <= p_idx_d;
            push_q   <= push_d;
            rd_idx_q <= rd_idx_d;
            start_q  <= start_d;
        end
    end

    always_ff @(posedge clock_i) begin
        a_q <= a_d;
    end

    fios_word_ram #(.DEPTH(s), .AW(IDX_W), .RD_WORDS(PE_NB)) u_a_ram (
        .clk_i(clock_i), .we_i(a_we), .waddr_i(a_ld_q), .wdata_i(load_data_i),
        .raddr_i(a_base), .rdata_o(a_d)
    );
    fios_word_ram #(.DEPTH(s), .AW(IDX_W), .RD_WORDS(1)) u_b_ram (
        .clk_i(clock_i), .we_i(b_we), .waddr_i(b_ld_q), .wdata_i(load_data_i),
        .raddr_i(b_idx_q), .rdata_o(b_rd)
    );
    fios_word_ram #(.DEPTH(s), .AW(IDX_W), .RD_WORDS(1)) u_p_ram (
        .clk_i(clock_i), .we_i(p_we), .waddr_i(p_ld_q), .wdata_i(load_data_i),
        .raddr_i(p_idx_q), .rdata_o(p_rd)
    );
    fios_word_ram #(.DEPTH(s), .AW(IDX_W), .RD_WORDS(1)) u_res_ram (
        .clk_i(clock_i), .we_i(r_we), .waddr_i(push_q), .wdata_i(res_i),
        .raddr_i(rd_idx_q), .rdata_o(r_rd)
    );

`ifdef FIOS_OPSRV_PUSH_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (go_accept) err_d = 1'b0;
        if ((state_q == RUN) && done_i && (push_d != S_IDX)) err_d = 1'b1;
        if ((state_q != RUN) && res_push_i) err_d = 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign start_o      = start_q;
    assign busy_o       = (state_q == RUN);
    assign load_ready_o = (state_q != RUN);
    assign res_valid_o  = (state_q == DONE);
    assign a_o          = a_q;
    assign b_o          = b_rd;
    assign p_o          = p_rd;
    assign res_data_o   = r_rd;
endmodule

// File: tb/tb_fios_operand_server.sv
// Randomized self-checking bench for fios_operand_server against an array-based model.
module tb_fios_operand_server;
    localparam int S  = 8;
    localparam int PE = 3;
    localparam int AG = (S + PE - 1) / PE;
    localparam int W  = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, load_valid_i, go_i, a_shift_i, b_fetch_i, p_fetch_i;
    logic          res_push_i, done_i, res_rd_i;
    logic [1:0]    load_sel_i;
    logic [W-1:0]  load_data_i, res_i;
    logic          load_ready_o, busy_o, start_o, res_valid_o, err_o;
    logic [PE*W-1:0] a_o;
    logic [W-1:0]  b_o, p_o, res_data_o;

    fios_operand_server #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clk), .reset_i(reset_i),
        .load_valid_i(load_valid_i), .load_sel_i(load_sel_i), .load_data_i(load_data_i),
        .load_ready_o(load_ready_o), .go_i(go_i), .busy_o(busy_o), .start_o(start_o),
        .a_o(a_o), .a_shift_i(a_shift_i), .b_o(b_o), .b_fetch_i(b_fetch_i),
        .p_o(p_o), .p_fetch_i(p_fetch_i), .res_i(res_i), .res_push_i(res_push_i),
        .done_i(done_i), .res_valid_o(res_valid_o), .res_rd_i(res_rd_i),
        .res_data_o(res_data_o), .err_o(err_o)
    );

    int checks = 0;
    int errs   = 0;

    // Reference model: operand/result contents plus the host-visible indices.
    logic [W-1:0] mem [3][S];
    logic [W-1:0] mres [S];
    int cnt [3];
    int g, bi, pi, pc;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_group(input int grp);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < PE; j++) begin
            if (grp * PE + j < S) v[j*W +: W] = mem[0][grp * PE + j];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] plan_word(input int sel, input int k);
        case (sel)
            0:       return W'(k + 1);
            1:       return W'('h10 + k);
            default: return W'('h1FFFF - k);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int sel, input logic [W-1:0] data);
        load_valid_i = 1'b1;
        load_sel_i   = 2'(sel);
        load_data_i  = data;
        step();
        load_valid_i = 1'b0;
        if (sel != 3 && cnt[sel] < S) begin
            mem[sel][cnt[sel]] = data;
            cnt[sel]++;
        end
    endtask

    task automatic load_phase(input bit plan);
        int guard;
        int sel;
        guard = 0;
        while ((3 * S - (cnt[0] + cnt[1] + cnt[2])) > 1 && guard < 2000) begin
            guard++;
            sel = $urandom_range(0, 3);
            if (sel == 3) load_word(3, W'($urandom));
            else if (cnt[sel] < S) load_word(sel, plan ? plan_word(sel, cnt[sel]) : W'($urandom));
            else if ($urandom_range(0, 3) == 0) load_word(sel, W'($urandom));
        end
        go_i = 1'b1;
        step();
        go_i = 1'b0;
        chk_eq("go_partial_start", start_o, 1'b0);
        chk_eq("go_partial_busy", busy_o, 1'b0);
        chk_eq("go_partial_ready", load_ready_o, 1'b1);
        chk_eq("load_res_valid", res_valid_o, 1'b0);
        for (int t = 0; t < 3; t++) begin
            while (cnt[t] < S) load_word(t, plan ? plan_word(t, cnt[t]) : W'($urandom));
        end
        load_word($urandom_range(0, 2), W'($urandom));
    endtask

    task automatic go_phase();
        go_i = 1'b1;
        step();
        go_i = 1'b0;
        g = 0; bi = 0; pi = 0; pc = 0;
        for (int t = 0; t < 3; t++) cnt[t] = 0;
        chk_eq("go_start", start_o, 1'b1);
        chk_eq("go_busy", busy_o, 1'b1);
        chk_eq("go_ready", load_ready_o, 1'b0);
        chk_eq("go_res_valid", res_valid_o, 1'b0);
        chk_eq("go_a0", a_o, exp_group(0));
        chk_eq("go_b0", b_o, mem[1][0]);
        chk_eq("go_p0", p_o, mem[2][0]);
        chk_eq("go_err", err_o, 1'b0);
        step();
        chk_eq("start_once", start_o, 1'b0);
    endtask

    task automatic run_phase(input int tgt, input bit plan, input int abort_at);
        int issued;
        int cyc;
        bit sh, bf, pf, push, last;
        logic [W-1:0] v;
        issued = 0;
        cyc = 0;
        while (cyc < 200) begin
            sh   = ($urandom_range(0, 2) == 0);
            bf   = ($urandom_range(0, 2) == 0);
            pf   = ($urandom_range(0, 2) == 0);
            last = (issued == tgt - 1) && (cyc >= 12);
            push = last || ((issued < tgt - 1) && ($urandom_range(0, 1) == 1 || cyc >= 16));
            v    = plan ? W'('hA0 + issued) : W'($urandom);
            a_shift_i = sh; b_fetch_i = bf; p_fetch_i = pf;
            res_push_i = push; res_i = v; done_i = last;
            load_valid_i = !last && ($urandom_range(0, 3) == 0);
            load_sel_i = 2'($urandom);
            load_data_i = W'($urandom);
            go_i = !last && ($urandom_range(0, 4) == 0);
            reset_i = (cyc == abort_at);
            step();
            a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_push_i = 0; done_i = 0;
            load_valid_i = 0; go_i = 0; reset_i = 0;
            if (cyc == abort_at) begin
                chk_eq("rst_busy", busy_o, 1'b0);
                chk_eq("rst_ready", load_ready_o, 1'b1);
                chk_eq("rst_start", start_o, 1'b0);
                chk_eq("rst_res_valid", res_valid_o, 1'b0);
                chk_eq("rst_err", err_o, 1'b0);
                b_fetch_i = 1'b1; p_fetch_i = 1'b1;
                step();
                b_fetch_i = 1'b0; p_fetch_i = 1'b0;
                chk_eq("idle_b_ignored", b_o, mem[1][0]);
                chk_eq("idle_p_ignored", p_o, mem[2][0]);
                return;
            end
            if (sh) g = (g + 1) % AG;
            if (bf) bi = (bi + 1) % S;
            if (pf) pi = (pi + 1) % S;
            if (push) begin
                if (pc < S) begin
                    mres[pc] = v;
                    pc++;
                end
                issued++;
            end
            chk_eq("run_a", a_o, exp_group(g));
            chk_eq("run_b", b_o, mem[1][bi]);
            chk_eq("run_p", p_o, mem[2][pi]);
            if (last) return;
            chk_eq("run_busy", busy_o, 1'b1);
            cyc++;
        end
        chk_eq("run_budget", 1'b1, 1'b0);
    endtask

    task automatic done_phase(input int tgt);
        chk_eq("done_res_valid", res_valid_o, 1'b1);
        chk_eq("done_busy", busy_o, 1'b0);
        chk_eq("done_ready", load_ready_o, 1'b1);
`ifdef FIOS_OPSRV_PUSH_CHECK_EN
        chk_eq("done_err", err_o, (tgt < S));
`else
        chk_eq("done_err", err_o, 1'b0);
`endif
        for (int i = 0; i < 2 * S; i++) begin
            chk_eq("res_read", res_data_o, mres[i % S]);
            res_rd_i = 1'b1;
            step();
            res_rd_i = 1'b0;
        end
        go_i = 1'b1;
        step();
        go_i = 1'b0;
        chk_eq("done_go_noload", start_o, 1'b0);
        chk_eq("done_go_valid", res_valid_o, 1'b1);
`ifdef FIOS_OPSRV_PUSH_CHECK_EN
        res_push_i = 1'b1;
        step();
        res_push_i = 1'b0;
        chk_eq("push_outside_run_err", err_o, 1'b1);
`endif
    endtask

    initial begin
        int tgt;
        reset_i = 1; load_valid_i = 0; load_sel_i = 0; load_data_i = 0; go_i = 0;
        a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_i = 0; res_push_i = 0;
        done_i = 0; res_rd_i = 0;
        for (int t = 0; t < 3; t++) cnt[t] = 0;
        step();
        step();
        reset_i = 0;
        chk_eq("reset_busy", busy_o, 1'b0);
        chk_eq("reset_start", start_o, 1'b0);
        chk_eq("reset_res_valid", res_valid_o, 1'b0);
        chk_eq("reset_ready", load_ready_o, 1'b1);
        chk_eq("reset_err", err_o, 1'b0);
        go_i = 1'b1;
        step();
        go_i = 1'b0;
        chk_eq("go_empty_start", start_o, 1'b0);

        for (int r = 0; r < 6; r++) begin
            if (r == 0)      tgt = S;
            else if (r == 1) tgt = S - 1;
            else             tgt = $urandom_range(S - 2, S + 2);
            load_phase(r == 0);
            go_phase();
            if (r == 2) begin
                run_phase(tgt, 1'b0, 5);
            end else begin
                run_phase(tgt, r == 0, -1);
                done_phase(tgt);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
